// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the RV32 core's load path.
//   XLEN           : data / address width (only 32 is supported)
//   F3_*           : load funct3 encodings
//   ld_state_e     : load unit state encoding (LD_IDLE, LD_REQ, LD_RESP)
//   is_legal_load  : funct3 is one of the five load encodings
//   is_misaligned  : access straddles its natural alignment
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_REQ  = 2'd1,
        LD_RESP = 2'd2
    } ld_state_e;

    function automatic logic is_legal_load(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        if ((f3 == F3_LH) || (f3 == F3_LHU)) return lo[0];
        if (f3 == F3_LW)                     return (lo != 2'b00);
        return 1'b0;
    endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational extraction and sign/zero extension of load data.
// Ports:
//   rdata   in  [XLEN-1:0]  word read from the data-memory bus
//   addr_lo in  [1:0]       low address bits of the load
//   funct3  in  [2:0]       load type
//   data    out [XLEN-1:0]  extracted, extended value (0 for illegal funct3)
// Halfword selection looks only at addr_lo[1]; addr_lo[0] is don't-care for
// LH/LHU and both bits are don't-care for LW.
// -----------------------------------------------------------------------------
module load_align (
    input  logic [cpu_pkg::XLEN-1:0] rdata,
    input  logic [1:0]               addr_lo,
    input  logic [2:0]               funct3,
    output logic [cpu_pkg::XLEN-1:0] data
);
    import cpu_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: assign a default before the case so no path leaves data
        // unassigned; otherwise synthesis infers a latch.
        data = '0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'b0, byte_sel};
            F3_LHU:  data = {16'b0, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
// Multi-cycle load unit: accepts a load from execute, performs one read on
// the data-memory bus with a req/ack handshake, and returns the extracted,
// extended data with a one-cycle done pulse.
// Parameters:
//   XLEN      data / address width (only 32 supported)
//   MAX_WAIT  bus timeout in REQ cycles; 0 disables the timeout
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   start      in   load command valid, sampled only in IDLE
//   addr       in   byte address
//   funct3     in   load type
//   busy       out  bus transaction in flight (REQ)
//   done       out  one-cycle completion pulse
//   err        out  error status, qualified by done
//   result     out  extended load data, held until the next done
//   mem_req    out  bus read request
//   mem_addr   out  word-aligned bus address
//   mem_ack    in   bus read data valid
//   mem_rdata  in   bus read data
// Build option:
//   LOAD_MISALIGN_TRAP_EN  misaligned LH/LHU/LW complete with err and no bus
//                          access; when undefined, unused low address bits
//                          are ignored.
// -----------------------------------------------------------------------------
module load_unit #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] addr,
    input  logic [2:0]      funct3,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] result,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);
    import cpu_pkg::*;

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

    ld_state_e       state;
    ld_state_e       next_state;
    logic [1:0]      lat_lo;
    logic [2:0]      lat_f3;
    logic [CNT_W-1:0] wait_cnt;
    logic [XLEN-1:0] align_data;
    logic            start_bad;
    logic            timeout;

    load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (lat_lo),
        .funct3  (lat_f3),
        .data    (align_data)
    );

`ifdef LOAD_MISALIGN_TRAP_EN
    assign start_bad = !is_legal_load(funct3) || is_misaligned(funct3, addr[1:0]);
`else
    assign start_bad = !is_legal_load(funct3);
`endif

    // Fires on the MAX_WAIT-th REQ cycle; an ack in that same cycle wins.
    assign timeout = (MAX_WAIT != 0) && (wait_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LD_IDLE;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge
            // values regardless of process evaluation order.
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            LD_IDLE: if (start) next_state = start_bad ? LD_RESP : LD_REQ;
            LD_REQ:  if (mem_ack || timeout) next_state = LD_RESP;
            LD_RESP: next_state = LD_IDLE;
            default: next_state = LD_IDLE;
        endcase
    end

    // Outputs decoded from state; mem_req therefore drops with the async reset.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        mem_req = 1'b0;
        case (state)
            LD_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
            end
            LD_RESP: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: command latch, wait counter, result/err capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            lat_lo   <= '0;
            lat_f3   <= '0;
            wait_cnt <= '0;
            result   <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                LD_IDLE: begin
                    if (start) begin
                        mem_addr <= {addr[XLEN-1:2], 2'b00};
                        lat_lo   <= addr[1:0];
                        lat_f3   <= funct3;
                        wait_cnt <= '0;
                        if (start_bad) begin
                            result <= '0;
                            err    <= 1'b1;
                        end
                    end
                end
                LD_REQ: begin
                    if (mem_ack) begin
                        result <= align_data;
                        err    <= 1'b0;
                    end else if (timeout) begin
                        result <= '0;
                        err    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// -----------------------------------------------------------------------------
// tb_load_unit
// Directed self-checking bench for load_unit (default MAX_WAIT and a
// MAX_WAIT=4 instance) and for load_align standalone. Honours
// LOAD_MISALIGN_TRAP_EN for the misaligned-LW step.
// -----------------------------------------------------------------------------
module tb_load_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance (MAX_WAIT = 255)
    logic        start, busy, done, err, mem_req, mem_ack;
    logic [31:0] addr, result, mem_addr, mem_rdata;
    logic [2:0]  funct3;

    // Timeout instance (MAX_WAIT = 4)
    logic        t_start, t_busy, t_done, t_err, t_mem_req, t_ack;
    logic [31:0] t_addr, t_result, t_mem_addr, t_rdata;
    logic [2:0]  t_funct3;

    // Standalone aligner
    logic [31:0] a_rdata, a_data;
    logic [1:0]  a_lo;
    logic [2:0]  a_f3;

    int   req_cycles;
    logic seen;

    load_unit dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .funct3(funct3),
        .busy(busy), .done(done), .err(err), .result(result),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    load_unit #(.XLEN(32), .MAX_WAIT(4)) dut_to (
        .clk(clk), .rst(rst), .start(t_start), .addr(t_addr), .funct3(t_funct3),
        .busy(t_busy), .done(t_done), .err(t_err), .result(t_result),
        .mem_req(t_mem_req), .mem_addr(t_mem_addr), .mem_ack(t_ack), .mem_rdata(t_rdata)
    );

    load_align u_align (.rdata(a_rdata), .addr_lo(a_lo), .funct3(a_f3), .data(a_data));

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Start a load, then ack in the first REQ cycle; returns in the done cycle.
    task automatic fast_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd);
        addr = a; funct3 = f3; start = 1'b1;
        cyc();
        start = 1'b0;
        mem_ack = 1'b1; mem_rdata = rd;
        cyc();
        mem_ack = 1'b0;
    endtask

    initial begin
        start = 1'b0; addr = '0; funct3 = '0; mem_ack = 1'b0; mem_rdata = '0;
        t_start = 1'b0; t_addr = '0; t_funct3 = '0; t_ack = 1'b0; t_rdata = '0;
        a_rdata = '0; a_lo = '0; a_f3 = '0;

        // Reset values
        #2;
        check_bit ("rst_busy",     busy,     1'b0);
        check_bit ("rst_done",     done,     1'b0);
        check_bit ("rst_err",      err,      1'b0);
        check_word("rst_result",   result,   32'h0);
        check_bit ("rst_mem_req",  mem_req,  1'b0);
        check_word("rst_mem_addr", mem_addr, 32'h0);
        check_bit ("rst_t_busy",   t_busy,   1'b0);
        #20 rst = 1'b0;
        cyc();

        // LW 0x100, ack in first REQ cycle: done two edges after start
        addr = 32'h100; funct3 = F3_LW; start = 1'b1;
        cyc();
        start = 1'b0;
        check_bit ("lw_req",    mem_req,  1'b1);
        check_word("lw_addr",   mem_addr, 32'h100);
        check_bit ("lw_busy",   busy,     1'b1);
        check_bit ("lw_nodone", done,     1'b0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        cyc();
        mem_ack = 1'b0;
        check_bit ("lw_done",   done,    1'b1);
        check_word("lw_result", result,  32'hDEADBEEF);
        check_bit ("lw_err",    err,     1'b0);
        check_bit ("lw_req_dn", mem_req, 1'b0);
        check_bit ("lw_busy_dn", busy,   1'b0);
        cyc();
        check_bit ("lw_pulse",  done,    1'b0);
        check_word("lw_hold",   result,  32'hDEADBEEF);

        // Byte loads
        fast_load(32'h203, F3_LB, 32'h80112233);
        check_bit ("lb_done",   done,     1'b1);
        check_word("lb_result", result,   32'hFFFFFF80);
        check_word("lb_addr",   mem_addr, 32'h200);
        cyc();
        fast_load(32'h203, F3_LBU, 32'h80112233);
        check_word("lbu_result", result, 32'h00000080);
        check_bit ("lbu_err",    err,    1'b0);
        cyc();

        // Halfword loads
        fast_load(32'h12, F3_LH, 32'h80017FFF);
        check_word("lh_result", result, 32'hFFFF8001);
        cyc();
        fast_load(32'h10, F3_LHU, 32'h80017FFF);
        check_word("lhu_result", result, 32'h00007FFF);
        cyc();

        // Ack delayed 5 cycles, start pulses ignored while in REQ
        addr = 32'h300; funct3 = F3_LW; start = 1'b1;
        cyc();
        addr = 32'h400; funct3 = F3_LB;
        req_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            start = ~start;
            if (mem_req) req_cycles++;
            check_word("dly_addr", mem_addr, 32'h300);
            check_bit ("dly_nodone", done, 1'b0);
            cyc();
        end
        start = 1'b0;
        if (mem_req) req_cycles++;
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        cyc();
        mem_ack = 1'b0;
        check_word("dly_req_cycles", req_cycles, 32'd6);
        check_bit ("dly_done",   done,   1'b1);
        check_word("dly_result", result, 32'h12345678);
        // start during RESP is ignored
        start = 1'b1; addr = 32'h500; funct3 = F3_LW;
        cyc();
        start = 1'b0;
        check_bit("resp_start_busy", busy,    1'b0);
        check_bit("resp_start_req",  mem_req, 1'b0);
        check_bit("resp_start_done", done,    1'b0);
        cyc();
        check_bit("dly_single_done", done,    1'b0);

        // Illegal funct3: straight to RESP, no bus request
        addr = 32'h600; funct3 = 3'b011; start = 1'b1;
        cyc();
        start = 1'b0;
        check_bit ("ill_done",   done,    1'b1);
        check_bit ("ill_err",    err,     1'b1);
        check_word("ill_result", result,  32'h0);
        check_bit ("ill_req",    mem_req, 1'b0);
        cyc();
        check_bit ("ill_pulse",  done,    1'b0);

        // Timeout instance: one good load, then no ack
        t_addr = 32'h40; t_funct3 = F3_LW; t_start = 1'b1;
        cyc();
        t_start = 1'b0; t_ack = 1'b1; t_rdata = 32'hCAFEF00D;
        cyc();
        t_ack = 1'b0;
        check_bit ("to_pre_done",   t_done,     1'b1);
        check_word("to_pre_result", t_result,   32'hCAFEF00D);
        check_word("to_pre_addr",   t_mem_addr, 32'h40);
        cyc();
        t_addr = 32'h44; t_start = 1'b1;
        cyc();
        t_start = 1'b0;
        seen = 1'b0; req_cycles = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (t_done) seen = 1'b1;
            else begin
                if (t_mem_req) req_cycles++;
                cyc();
            end
        end
        check_bit ("to_seen",       seen,      1'b1);
        check_word("to_req_cycles", req_cycles, 32'd4);
        check_bit ("to_err",        t_err,     1'b1);
        check_word("to_result",     t_result,  32'h0);
        check_bit ("to_req_dn",     t_mem_req, 1'b0);
        cyc();

        // Reset pulse while in REQ, then a stray ack
        addr = 32'h700; funct3 = F3_LW; start = 1'b1;
        cyc();
        start = 1'b0;
        check_bit("rr_req_before", mem_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_bit("rr_req_async", mem_req, 1'b0);
        check_bit("rr_busy",      busy,    1'b0);
        #1 rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        cyc();
        check_bit("rr_done1", done, 1'b0);
        cyc();
        mem_ack = 1'b0;
        check_bit ("rr_done2",  done,   1'b0);
        check_word("rr_result", result, 32'h0);

        // Misaligned LW at 0x102
        addr = 32'h102; funct3 = F3_LW; start = 1'b1;
        cyc();
        start = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
        check_bit ("ma_done",   done,    1'b1);
        check_bit ("ma_err",    err,     1'b1);
        check_word("ma_result", result,  32'h0);
        check_bit ("ma_req",    mem_req, 1'b0);
        cyc();
`else
        check_bit ("ma_req",  mem_req,  1'b1);
        check_word("ma_addr", mem_addr, 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'hA5A51234;
        cyc();
        mem_ack = 1'b0;
        check_bit ("ma_done",   done,   1'b1);
        check_word("ma_result", result, 32'hA5A51234);
        check_bit ("ma_err",    err,    1'b0);
        cyc();
`endif

        // Standalone aligner vectors
        a_rdata = 32'h80112233; a_lo = 2'd0; a_f3 = F3_LB;  #1;
        check_word("al_lb0",  a_data, 32'h00000033);
        a_lo = 2'd1; #1;
        check_word("al_lb1",  a_data, 32'h00000022);
        a_lo = 2'd2; a_f3 = F3_LBU; #1;
        check_word("al_lbu2", a_data, 32'h00000011);
        a_rdata = 32'h1234F00D; a_lo = 2'd0; a_f3 = F3_LH; #1;
        check_word("al_lh0",  a_data, 32'hFFFFF00D);
        a_lo = 2'd3; a_f3 = F3_LHU; #1;
        check_word("al_lhu3", a_data, 32'h00001234);
        a_f3 = 3'b110; #1;
        check_word("al_ill",  a_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
